// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding as plain localparams (so older code that
// compares raw state bits keeps working) and the enum built on top of them.
// Nothing in here depends on the operand width.
// ---------------------------------------------------------------------------
package divider_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_addsub_chain.sv
// ---------------------------------------------------------------------------
// full_adder_subtractor / addsub_chain
// One-bit adder/subtractor cell and an N-bit ripple built from it.
// With mode_i=1 the B operand is inverted inside each cell, so feeding
// cin_i=1 gives A-B in two's complement; cout_o=1 then means "no borrow".
//
// full_adder_subtractor ports:
//   a_i, b_i   operand bits
//   mode_i     0 = add, 1 = subtract (inverts b_i)
//   cin_i      carry in
//   sum_o      sum / difference bit
//   cout_o     carry out
//
// addsub_chain ports:
//   a_i, b_i   N-bit operands
//   mode_i     shared add/subtract select
//   cin_i      carry into the LSB cell
//   sum_o      N-bit result
//   cout_o     carry out of the MSB cell
// ---------------------------------------------------------------------------
module full_adder_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic mode_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic bEff;

    assign bEff   = b_i ^ mode_i;
    assign sum_o  = a_i ^ bEff ^ cin_i;
    assign cout_o = (a_i & bEff) | (a_i & cin_i) | (bEff & cin_i);

endmodule

module addsub_chain #(
    parameter int N = 9
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         mode_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < N; i++) begin : g_cell
        full_adder_subtractor u_cell (
            .a_i    (a_i[i]),
            .b_i    (b_i[i]),
            .mode_i (mode_i),
            .cin_i  (carry[i]),
            .sum_o  (sum_o[i]),
            .cout_o (carry[i+1])
        );
    end

    assign cout_o = carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
// Unsigned WIDTH-bit restoring divider, one quotient bit per clock.
// A start seen in IDLE captures the operands; the divider then runs WIDTH
// trial subtractions and spends one cycle in DONE with done high.
// A zero divisor skips straight to DONE with an all-ones quotient,
// remainder = dividend and div_by_zero set.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, only looked at in IDLE
//   dividend     captured on an accepted start
//   divisor      captured on an accepted start
//   busy         high whenever not IDLE
//   done         one-cycle pulse, results valid from this cycle
//   quotient     held until the next result
//   remainder    held until the next result
//   div_by_zero  held with the results, cleared by an accepted start
// ---------------------------------------------------------------------------
module seq_restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shiftRem;
    logic [WIDTH:0]   trial;
    logic             noBorrow;
    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuo;
    logic             unusedTrialMsb;

    // Trial subtraction of the shifted partial remainder against the divisor.
    // R < D always holds, so the shifted value fits in WIDTH+1 bits and the
    // difference, when kept, always has a zero MSB.
    assign shiftRem = {r_q, q_q[WIDTH-1]};

    addsub_chain #(
        .N (WIDTH + 1)
    ) u_chain (
        .a_i    (shiftRem),
        .b_i    ({1'b0, d_q}),
        .mode_i (1'b1),
        .cin_i  (1'b1),
        .sum_o  (trial),
        .cout_o (noBorrow)
    );

    assign unusedTrialMsb = trial[WIDTH];
    assign stepRem        = noBorrow ? trial[WIDTH-1:0] : shiftRem[WIDTH-1:0];
    assign stepQuo        = {q_q[WIDTH-2:0], noBorrow};

    // Next-state logic: operand capture in IDLE, one restoring step per cycle
    // in RUN, and result registers written only on the way into DONE.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        state_d = RUN;
                        q_d     = dividend;
                        r_d     = '0;
                        d_d     = divisor;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                q_d = stepQuo;
                r_d = stepRem;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    quo_d   = stepQuo;
                    rem_d   = stepRem;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
// Drives an 8-bit and a 16-bit divider instance. Every accepted request
// pushes the arithmetic answer onto a per-instance queue; a monitor per
// instance pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic        start8, busy8, done8, dbz8;
    logic [7:0]  dvd8, dvs8, q8, r8;
    logic        start16, busy16, done16, dbz16;
    logic [15:0] dvd16, dvs16, q16, r16;

    seq_restoring_divider #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start8),
        .dividend    (dvd8),
        .divisor     (dvs8),
        .busy        (busy8),
        .done        (done8),
        .quotient    (q8),
        .remainder   (r8),
        .div_by_zero (dbz8)
    );

    seq_restoring_divider #(.WIDTH(16)) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start16),
        .dividend    (dvd16),
        .divisor     (dvs16),
        .busy        (busy16),
        .done        (done16),
        .quotient    (q16),
        .remainder   (r16),
        .div_by_zero (dbz16)
    );

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t exp8[$];
    exp_t exp16[$];
    int   checks = 0;
    int   errors = 0;

    // Compare one observed value against the value the bench worked out.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Plain-arithmetic reference: quotient and remainder by / and %.
    function automatic exp_t refModel(input int w, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 0) begin
            e.q   = (w == 8) ? 32'hFF : 32'hFFFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Called at a negedge with the instance idle: raises start for one edge
    // and records the expected answer. Returns at the negedge of cycle 1.
    task automatic applyStimulus(input int w, input logic [31:0] a, input logic [31:0] b);
        if (w == 8) begin
            dvd8   = a[7:0];
            dvs8   = b[7:0];
            start8 = 1'b1;
            exp8.push_back(refModel(8, {24'b0, a[7:0]}, {24'b0, b[7:0]}));
        end else begin
            dvd16   = a[15:0];
            dvs16   = b[15:0];
            start16 = 1'b1;
            exp16.push_back(refModel(16, {16'b0, a[15:0]}, {16'b0, b[15:0]}));
        end
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    // Full operation at minimum start-to-start spacing.
    task automatic runOp(input int w, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(w, a, b);
        repeat (w + 1) @(negedge clk);
    endtask

    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n && done8) begin
            if (exp8.size() == 0) begin
                checkOutput("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e = exp8.pop_front();
                checkOutput("q8", {24'b0, q8}, e.q);
                checkOutput("r8", {24'b0, r8}, e.r);
                checkOutput("dbz8", {31'b0, dbz8}, {31'b0, e.dbz});
                checkOutput("busy8_at_done", {31'b0, busy8}, 32'd1);
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (rst_n && done16) begin
            if (exp16.size() == 0) begin
                checkOutput("unexpected_done16", 32'd1, 32'd0);
            end else begin
                e = exp16.pop_front();
                checkOutput("q16", {16'b0, q16}, e.q);
                checkOutput("r16", {16'b0, r16}, e.r);
                checkOutput("dbz16", {31'b0, dbz16}, {31'b0, e.dbz});
            end
        end
    end

    initial begin
        int doneCount;
        logic [31:0] dA [4] = '{255, 5, 0, 255};
        logic [31:0] dB [4] = '{1, 9, 3, 255};
        logic [31:0] a, b;

        rst_n   = 1'b0;
        start8  = 1'b0;
        start16 = 1'b0;
        dvd8    = '0;
        dvs8    = '0;
        dvd16   = '0;
        dvs16   = '0;
        repeat (2) @(negedge clk);

        checkOutput("rst_busy8", {31'b0, busy8}, 32'd0);
        checkOutput("rst_done8", {31'b0, done8}, 32'd0);
        checkOutput("rst_q8", {24'b0, q8}, 32'd0);
        checkOutput("rst_r8", {24'b0, r8}, 32'd0);
        checkOutput("rst_dbz8", {31'b0, dbz8}, 32'd0);
        checkOutput("rst_busy16", {31'b0, busy16}, 32'd0);
        checkOutput("rst_q16", {16'b0, q16}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 100/7: done only in cycle 9, busy in cycles 1..9
        applyStimulus(8, 100, 7);
        for (int c = 1; c <= 11; c++) begin
            checkOutput($sformatf("done8_c%0d", c), {31'b0, done8}, (c == 9) ? 32'd1 : 32'd0);
            checkOutput($sformatf("busy8_c%0d", c), {31'b0, busy8}, (c <= 9) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 4; i++) begin
            runOp(8, dA[i], dB[i]);
        end
        checkOutput("q8_held_idle", {24'b0, q8}, 32'd1);

        // divide by zero finishes in cycle 1, next op clears the flag
        applyStimulus(8, 200, 0);
        checkOutput("dbz_done_c1", {31'b0, done8}, 32'd1);
        repeat (9) @(negedge clk);
        runOp(8, 10, 3);
        checkOutput("dbz8_cleared", {31'b0, dbz8}, 32'd0);

        // start re-pulsed in cycles 3 and 9 must be ignored
        applyStimulus(8, 100, 7);
        doneCount = 0;
        for (int c = 1; c <= 12; c++) begin
            if (done8) doneCount++;
            start8 = (c == 3 || c == 9);
            dvd8   = 8'd9;
            dvs8   = 8'd0;
            @(negedge clk);
        end
        start8 = 1'b0;
        checkOutput("restart_done_count", doneCount, 32'd1);
        checkOutput("restart_q8", {24'b0, q8}, 32'd14);

        // asynchronous reset in the middle of cycle 4 of a run
        applyStimulus(8, 100, 7);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp8.delete();
        #1;
        checkOutput("midrst_busy8", {31'b0, busy8}, 32'd0);
        checkOutput("midrst_done8", {31'b0, done8}, 32'd0);
        checkOutput("midrst_q8", {24'b0, q8}, 32'd0);
        checkOutput("midrst_r8", {24'b0, r8}, 32'd0);
        checkOutput("midrst_dbz8", {31'b0, dbz8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runOp(8, 50, 6);

        // 16-bit latency: done in cycle 17
        applyStimulus(16, 60000, 300);
        repeat (15) @(negedge clk);
        checkOutput("done16_c16", {31'b0, done16}, 32'd0);
        @(negedge clk);
        checkOutput("done16_c17", {31'b0, done16}, 32'd1);
        @(negedge clk);

        // random back-to-back traffic at minimum spacing
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 255);
            b = (i % 10 == 0) ? 32'd0 : $urandom_range(0, 255);
            runOp(8, a, b);
        end
        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, 65535);
            b = (i % 8 == 0) ? $urandom_range(1, 3) : $urandom_range(0, 65535);
            runOp(16, a, b);
        end

        for (int k = 0; k < 50 && (exp8.size() != 0 || exp16.size() != 0); k++) begin
            @(negedge clk);
        end
        checkOutput("pending8", exp8.size(), 32'd0);
        checkOutput("pending16", exp16.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
